// File: rtl/fft_buf_pkg.sv
// -----------------------------------------------------------------------------
// fft_buf_pkg
// Shared definitions for the ping-pong complex-sample buffer:
//   - bank_state_t : per-bank ownership state
//   - depth_of()   : words per bank for a given address width
//   - bit_reverse(): reverses the low w bits of an address
// Optional build macro used by the users of this package: FFT_BITREV_RD_EN.
// -----------------------------------------------------------------------------
package fft_buf_pkg;

    // Bank life cycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Bit k of the input lands on bit w-1-k of the result; bits >= w are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] a,
                                                input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned k = 0; k < w; k++) begin
            r[w-1-k] = a[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/cbuf_bank.sv
// -----------------------------------------------------------------------------
// cbuf_bank
// One bank of the ping-pong buffer: simple dual-port RAM, DEPTH x W, with a
// registered read address. All updates are gated by the global enable.
// Ports:
//   clk   in  clock, rising edge
//   ed    in  global enable; RAM writes and read-address updates only when 1
//   we    in  write strobe
//   waddr in  [AW-1:0] write address
//   wdata in  [W-1:0]  write data
//   re    in  read strobe (captures raddr)
//   raddr in  [AW-1:0] read address
//   rdata out [W-1:0]  word at the last captured read address
// -----------------------------------------------------------------------------
module cbuf_bank
    import fft_buf_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          ed,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int DEPTH = int'(depth_of(AW));

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] raddr_q;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ed) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                raddr_q <= raddr;
            end
        end
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/pingpong_cbuf.sv
// -----------------------------------------------------------------------------
// pingpong_cbuf
// Double-buffered complex-sample RAM for FFT pipeline stages. One bank fills
// while the other drains; banks change hands only on WLAST / RLAST markers.
// Optional build macro: FFT_BITREV_RD_EN -- when defined, the read address is
// bit-reversed before addressing the RAM (writes are unaffected).
// Parameters: NB (part width), AW (address width), RD_LAT (1 or 2).
// Ports:
//   CLK, RSTN (async active-low), ED (global enable, freezes everything)
//   WE, ADDRW, DR, DI, WLAST -> write side; WRDY out
//   RE, ADDRR, RLAST         -> read side;  RRDY out
//   DOR, DOI, DVLD           -> read data and valid
//   BANK_FULL[1:0]           -> bank i is FULL or DRAINING
//   OVF / UNF                -> sticky write-overflow / read-underflow
// Handshake: a write is accepted on a rising edge with ED & WE & WRDY, a read
// with ED & RE & RRDY. WRDY/RRDY depend on registered state only, never on
// WE/RE, so a request may be held until the ready is seen.
// -----------------------------------------------------------------------------
module pingpong_cbuf
    import fft_buf_pkg::*;
#(
    parameter int NB     = 16,
    parameter int AW     = 5,
    parameter int RD_LAT = 2
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          ED,
    input  logic          WE,
    input  logic [AW-1:0] ADDRW,
    input  logic [NB-1:0] DR,
    input  logic [NB-1:0] DI,
    input  logic          WLAST,
    output logic          WRDY,
    input  logic          RE,
    input  logic [AW-1:0] ADDRR,
    input  logic          RLAST,
    output logic          RRDY,
    output logic [NB-1:0] DOR,
    output logic [NB-1:0] DOI,
    output logic          DVLD,
    output logic [1:0]    BANK_FULL,
    output logic          OVF,
    output logic          UNF
);

    localparam int W = 2 * NB;

    bank_state_t   bst [0:1];
    logic          wb;
    logic          rb;
    logic          ovf_q;
    logic          unf_q;
    logic          vld1;
    logic          rsel;
    logic [W-1:0]  out_q;
    logic [W-1:0]  rdata0;
    logic [W-1:0]  rdata1;
    logic [W-1:0]  rd_mux;
    logic [W-1:0]  dout;
    logic [AW-1:0] raddr_phys;
    logic          wr_acc;
    logic          rd_acc;

    assign WRDY = (bst[wb] == ST_EMPTY) || (bst[wb] == ST_FILLING);
    assign RRDY = (bst[rb] == ST_FULL)  || (bst[rb] == ST_DRAINING);

    assign wr_acc = ED && WE && WRDY;
    assign rd_acc = ED && RE && RRDY;

    assign BANK_FULL[0] = (bst[0] == ST_FULL) || (bst[0] == ST_DRAINING);
    assign BANK_FULL[1] = (bst[1] == ST_FULL) || (bst[1] == ST_DRAINING);
    assign OVF = ovf_q;
    assign UNF = unf_q;

`ifdef FFT_BITREV_RD_EN
    assign raddr_phys = AW'(bit_reverse(32'(ADDRR), AW));
`else
    assign raddr_phys = ADDRR;
`endif

    // Bank ownership, pointers, sticky errors and the first read stage.
    // A write and a read accepted in the same cycle always hit different
    // banks (writable and readable states are disjoint), so both bank
    // updates can be applied independently.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bst[0] <= ST_EMPTY;
            bst[1] <= ST_EMPTY;
            wb     <= 1'b0;
            rb     <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            vld1   <= 1'b0;
            rsel   <= 1'b0;
        end else if (ED) begin
            if (wr_acc) begin
                bst[wb] <= WLAST ? ST_FULL : ST_FILLING;
                if (WLAST) begin
                    wb <= ~wb;
                end
            end
            if (rd_acc) begin
                bst[rb] <= RLAST ? ST_EMPTY : ST_DRAINING;
                if (RLAST) begin
                    rb <= ~rb;
                end
                rsel <= rb;
            end
            if (WE && !WRDY) begin
                ovf_q <= 1'b1;
            end
            if (RE && !RRDY) begin
                unf_q <= 1'b1;
            end
            vld1 <= rd_acc;
        end
    end

    cbuf_bank #(.W(W), .AW(AW)) u_bank0 (
        .clk   (CLK),
        .ed    (ED),
        .we    (wr_acc && (wb == 1'b0)),
        .waddr (ADDRW),
        .wdata ({DR, DI}),
        .re    (rd_acc && (rb == 1'b0)),
        .raddr (raddr_phys),
        .rdata (rdata0)
    );

    cbuf_bank #(.W(W), .AW(AW)) u_bank1 (
        .clk   (CLK),
        .ed    (ED),
        .we    (wr_acc && (wb == 1'b1)),
        .waddr (ADDRW),
        .wdata ({DR, DI}),
        .re    (rd_acc && (rb == 1'b1)),
        .raddr (raddr_phys),
        .rdata (rdata1)
    );

    assign rd_mux = rsel ? rdata1 : rdata0;

    // Holds the most recent delivered word so DOR/DOI stay put while DVLD=0.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_q <= '0;
        end else if (ED && vld1) begin
            out_q <= rd_mux;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Word is delivered straight from the RAM in the cycle after
            // acceptance; out_q keeps it once DVLD drops.
            assign dout = vld1 ? rd_mux : out_q;
            assign DVLD = vld1;
        end else begin : g_lat2
            logic vld2;
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    vld2 <= 1'b0;
                end else if (ED) begin
                    vld2 <= vld1;
                end
            end
            assign dout = out_q;
            assign DVLD = vld2;
        end
    endgenerate

    assign DOR = dout[W-1:NB];
    assign DOI = dout[NB-1:0];

endmodule

// File: tb/tb_pingpong_cbuf.sv
// -----------------------------------------------------------------------------
// tb_pingpong_cbuf
// Self-checking bench for pingpong_cbuf (NB=16, AW=5, RD_LAT=2). A reference
// model tracks bank ownership with plain integers, stores written words in an
// array, and schedules expected read results by ED-cycle count.
// -----------------------------------------------------------------------------
module tb_pingpong_cbuf;

    localparam int NB     = 16;
    localparam int AW     = 5;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 32;
    localparam int W      = 2 * NB;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RSTN;
    logic          ED, WE, WLAST, RE, RLAST;
    logic [AW-1:0] ADDRW, ADDRR;
    logic [NB-1:0] DR, DI;
    logic          WRDY, RRDY, DVLD, OVF, UNF;
    logic [NB-1:0] DOR, DOI;
    logic [1:0]    BANK_FULL;

    always #5 CLK = ~CLK;

    pingpong_cbuf #(.NB(NB), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .ED        (ED),
        .WE        (WE),
        .ADDRW     (ADDRW),
        .DR        (DR),
        .DI        (DI),
        .WLAST     (WLAST),
        .WRDY      (WRDY),
        .RE        (RE),
        .ADDRR     (ADDRR),
        .RLAST     (RLAST),
        .RRDY      (RRDY),
        .DOR       (DOR),
        .DOI       (DOI),
        .DVLD      (DVLD),
        .BANK_FULL (BANK_FULL),
        .OVF       (OVF),
        .UNF       (UNF)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;

    int         m_bs [2];       // 0 empty, 1 filling, 2 full, 3 draining
    int         m_wb, m_rb;
    bit         m_ovf, m_unf;
    logic [W-1:0] m_mem [2][DEPTH];
    logic [W-1:0] exp_q [$];    // expected read words, in order
    int           due_q [$];    // ED-edge count at which each word shows
    int           ed_cnt;
    logic [W-1:0] m_last;

    // DUT values sampled just before the edge of the latest tick
    logic         pre_wrdy, pre_rrdy, pre_unf;
    logic [1:0]   pre_bf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phys(input int ra);
        int r;
`ifdef FFT_BITREV_RD_EN
        r = 0;
        for (int k = 0; k < AW; k++) begin
            if (((ra >> k) & 1) != 0) r = r | (1 << (AW - 1 - k));
        end
`else
        r = ra;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        m_bs[0] = 0;
        m_bs[1] = 0;
        m_wb    = 0;
        m_rb    = 0;
        m_ovf   = 0;
        m_unf   = 0;
        exp_q.delete();
        due_q.delete();
        m_last  = '0;
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] dr,
                        input logic [NB-1:0] di, input logic wl, input logic re,
                        input logic [AW-1:0] ra, input logic rl, input logic ed);
        bit m_wrdy, m_rrdy, wacc, racc, exp_v;
        @(negedge CLK);
        WE = we; ADDRW = wa; DR = dr; DI = di; WLAST = wl;
        RE = re; ADDRR = ra; RLAST = rl; ED = ed;
        #1;
        m_wrdy = (m_bs[m_wb] == 0) || (m_bs[m_wb] == 1);
        m_rrdy = (m_bs[m_rb] == 2) || (m_bs[m_rb] == 3);
        pre_wrdy = WRDY; pre_rrdy = RRDY; pre_unf = UNF; pre_bf = BANK_FULL;
        chk("wrdy", WRDY, m_wrdy);
        chk("rrdy", RRDY, m_rrdy);
        chk("bank_full", BANK_FULL, {m_bs[1] >= 2, m_bs[0] >= 2});
        chk("ovf", OVF, m_ovf);
        chk("unf", UNF, m_unf);
        wacc = ed && we && m_wrdy;
        racc = ed && re && m_rrdy;
        @(posedge CLK);
        if (ed) begin
            ed_cnt++;
            if (we && !m_wrdy) m_ovf = 1;
            if (re && !m_rrdy) m_unf = 1;
            if (wacc) begin
                m_mem[m_wb][wa] = {dr, di};
                m_bs[m_wb] = wl ? 2 : 1;
                if (wl) m_wb = 1 - m_wb;
            end
            if (racc) begin
                exp_q.push_back(m_mem[m_rb][phys(int'(ra))]);
                due_q.push_back(ed_cnt + RD_LAT - 1);
                m_bs[m_rb] = rl ? 0 : 3;
                if (rl) m_rb = 1 - m_rb;
            end
            while (due_q.size() > 0 && due_q[0] < ed_cnt) begin
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
        #1;
        exp_v = (due_q.size() > 0) && (due_q[0] == ed_cnt);
        if (exp_v) m_last = exp_q[0];
        chk("dvld", DVLD, exp_v);
        chk("dor", DOR, m_last[W-1:NB]);
        chk("doi", DOI, m_last[NB-1:0]);
    endtask

    task automatic idle(input logic ed);
        tick(0, 0, 0, 0, 0, 0, 0, 0, ed);
    endtask

    task automatic reset_now();
        @(negedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        chk("rst_dvld", DVLD, 0);
        chk("rst_dor", DOR, 0);
        chk("rst_doi", DOI, 0);
        chk("rst_bank_full", BANK_FULL, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_unf", UNF, 0);
        chk("rst_wrdy", WRDY, 1);
        chk("rst_rrdy", RRDY, 0);
        model_reset();
        WE = 0; RE = 0; WLAST = 0; RLAST = 0; ED = 1;
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [NB-1:0] dr, di;
        logic          wl, re;
        logic [AW-1:0] ra;
        logic          rl, ed;
        logic          e_wrdy, e_rrdy;
        logic [1:0]    e_bf;
        logic          e_unf, e_dvld;
        logic [NB-1:0] e_dor;
    } vec_t;

    vec_t vt [7];
    int   dvld_run;
    logic [NB-1:0] bitrev_exp;

    initial begin
        // we wa dr di wl re ra rl ed | wrdy rrdy bf unf dvld dor
        vt[0] = '{0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 16'h0000};
        vt[1] = '{1, 3, 16'hAAAA, 16'h5555, 1, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 16'h0000};
        vt[2] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 2'b01, 1, 0, 16'h0000};
        vt[3] = '{0, 0, 16'h0000, 16'h0000, 0, 1, 3, 1, 1, 1, 1, 2'b01, 1, 0, 16'h0000};
        vt[4] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 1, 16'hAAAA};
        vt[5] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 16'hAAAA};
        vt[6] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 16'hAAAA};

        RSTN = 1'b0;
        ED = 0; WE = 0; RE = 0; WLAST = 0; RLAST = 0;
        ADDRW = 0; ADDRR = 0; DR = 0; DI = 0;
        ed_cnt = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("init_dvld", DVLD, 0);
        chk("init_dor", DOR, 0);
        chk("init_wrdy", WRDY, 1);
        chk("init_rrdy", RRDY, 0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Underflow on empty banks, single-word frame, single-read drain, ED hold.
        for (int i = 0; i < 7; i++) begin
            tick(vt[i].we, vt[i].wa, vt[i].dr, vt[i].di, vt[i].wl,
                 vt[i].re, vt[i].ra, vt[i].rl, vt[i].ed);
            chk($sformatf("tbl%0d_wrdy", i), pre_wrdy, vt[i].e_wrdy);
            chk($sformatf("tbl%0d_rrdy", i), pre_rrdy, vt[i].e_rrdy);
            chk($sformatf("tbl%0d_bf", i), pre_bf, vt[i].e_bf);
            chk($sformatf("tbl%0d_unf", i), pre_unf, vt[i].e_unf);
            chk($sformatf("tbl%0d_dvld", i), DVLD, vt[i].e_dvld);
            chk($sformatf("tbl%0d_dor", i), DOR, vt[i].e_dor);
        end

        // Full frame DR=i, DI=-i, then read back with continuous DVLD.
        for (int i = 0; i < DEPTH; i++)
            tick(1, AW'(i), NB'(i), NB'(0 - i), i == DEPTH - 1, 0, 0, 0, 1);
        chk("frame_rrdy", RRDY, 1);
        dvld_run = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) tick(0, 0, 0, 0, 0, 1, AW'(i), i == DEPTH - 1, 1);
            else           idle(1);
            if (DVLD) dvld_run++;
        end
        chk("frame_dvld_count", dvld_run, DEPTH);

        // Reset mid-frame with reads in flight.
        for (int i = 0; i < 4; i++) tick(1, AW'(i), NB'($urandom), NB'($urandom), i == 3, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 1, 0, 1);
        reset_now();

        // Three frames streamed: frame f+1 written while frame f is read.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < DEPTH; i++)
                tick(f < 3, AW'(i), NB'($urandom), NB'($urandom), (f < 3) && (i == DEPTH - 1),
                     f > 0, AW'(i), (f > 0) && (i == DEPTH - 1), 1);
        end
        repeat (3) idle(1);
        chk("stream_ovf", OVF, 0);
        chk("stream_unf", UNF, 0);

        // Fill both banks, attempt an extra write, then drain with an ED gap.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++)
                tick(1, AW'(i), NB'($urandom), NB'($urandom), i == DEPTH - 1, 0, 0, 0, 1);
        chk("both_full_wrdy", WRDY, 0);
        tick(1, 5, 16'hDEAD, 16'hBEEF, 0, 0, 0, 0, 1);
        idle(1);
        chk("ovf_set", OVF, 1);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) begin
                if (b == 0 && i == 10) repeat (3) tick(0, 0, 0, 0, 0, 1, AW'($urandom), 0, 0);
                tick(0, 0, 0, 0, 0, 1, AW'(i), i == DEPTH - 1, 1);
            end
        repeat (3) idle(1);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            tick($urandom_range(0, 1), AW'($urandom), NB'($urandom), NB'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1), AW'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0);
        end
        repeat (4) idle(1);
        chk("pending_empty", exp_q.size(), 0);

        // Read address 1 of a frame holding DR=i: bit-reversed order returns word 16.
        reset_now();
        for (int i = 0; i < DEPTH; i++) tick(1, AW'(i), NB'(i), 0, i == DEPTH - 1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1, 1, 1, 1);
        idle(1);
`ifdef FFT_BITREV_RD_EN
        bitrev_exp = 16'd16;
`else
        bitrev_exp = 16'd1;
`endif
        chk("addr1_dvld", DVLD, 1);
        chk("addr1_dor", DOR, bitrev_exp);
        repeat (2) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_cbuf.md
Name: pingpong_cbuf

Overview:
Parametrised double-buffered complex-sample RAM for the FFT pipeline stages. It generalises the fixed 2x32 ping-pong buffer to any data width and depth, with a selectable read latency. It replaces the external ODD toggle with internal bank ownership tracking and a write/read handshake. Writes fill one bank while the other bank drains. Banks swap only on explicit frame-last markers.

Parameters:
NB, 16, width of each real/imaginary part in bits
AW, 5, address width; each bank holds DEPTH = 2**AW complex words
RD_LAT, 2, read latency in ED-qualified cycles (legal values 1 or 2)

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
ED  in  1  global enable; when 0 all state, including the read pipeline, is frozen
WE  in  1  write request
ADDRW  in  AW  write address within the current write bank
DR  in  NB  write data, real part
DI  in  NB  write data, imaginary part
WLAST  in  1  with an accepted write, marks the last word of the frame
WRDY  out  1  write bank is available to accept writes
RE  in  1  read request
ADDRR  in  AW  read address within the current read bank
RLAST  in  1  with an accepted read, marks the last read of the frame
RRDY  out  1  a full bank is available to read
DOR  out  NB  read data, real part
DOI  out  NB  read data, imaginary part
DVLD  out  1  DOR/DOI valid
BANK_FULL  out  2  per-bank full flag (bit i = bank i)
OVF  out  1  sticky error: write attempted while WRDY=0
UNF  out  1  sticky error: read attempted while RRDY=0

Behaviour:
- Bank state per bank: EMPTY -> FILLING (first accepted write) -> FULL (accepted write with WLAST) -> DRAINING (first accepted read) -> EMPTY (accepted read with RLAST).
- A WLAST on the first write goes straight EMPTY -> FULL. An RLAST on the first read goes straight FULL -> EMPTY.
- Pointer wb selects the write bank; pointer rb selects the read bank. Both reset to 0.
- wb toggles on an accepted WLAST. rb toggles on an accepted RLAST.
- WRDY = bank[wb] is EMPTY or FILLING.
- RRDY = bank[rb] is FULL or DRAINING.
- Both are combinational from registered state only; there is no path from WE/RE to the ready outputs.
- Write is accepted when ED & WE & WRDY; {DR,DI} is stored at bank wb, address ADDRW.
- Read is accepted when ED & RE & RRDY; data is taken from bank rb, address ADDRR.
- Read data appears RD_LAT ED-cycles after acceptance, with DVLD high for exactly one ED-cycle per accepted read.
- The DVLD pipeline advances only when ED=1.
- DOR/DOI hold their last value when DVLD=0.
- Write and read never target the same bank, so there is no read-during-write hazard.
- Simultaneous WLAST on bank A and RLAST on bank B in one cycle: both transitions occur.
- Simultaneous WLAST on bank A and first read of bank A is impossible, because RRDY for A was 0 in that cycle.
- Both banks FULL: WRDY=0 until one bank is released by RLAST.
- Both banks EMPTY: RRDY=0.
- BANK_FULL[i] = bank i is FULL or DRAINING.
- OVF sets on ED & WE & ~WRDY; the write is dropped. UNF sets on ED & RE & ~RRDY; the read is dropped and no DVLD is produced. Both clear only on reset.
- Reset, asynchronous including mid-frame: all banks EMPTY; wb=rb=0; DVLD=0; DOR=DOI=0; OVF=UNF=0; BANK_FULL=0.
- Reset clears the read pipeline; in-flight reads are lost. RAM contents are not cleared.
- Addresses wrap naturally at DEPTH; no bound checks.

Optional Feature:
FFT_BITREV_RD_EN defined: the physical read address is ADDRR with its AW bits reversed (bit k -> bit AW-1-k), giving bit-reversed output order for the final stage.
FFT_BITREV_RD_EN undefined: ADDRR is used directly.
Writes are unaffected in both cases.

Decomposition:
- Shared package fft_buf_pkg holds:
  - bank state encoding (EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3);
  - the DEPTH calculation;
  - the bit-reverse function.
- One sub-module, cbuf_bank: simple dual-port RAM of DEPTH x 2*NB with a registered read address and ED gating.
- Two cbuf_bank instances hold the two banks. The top level holds the bank state machines, pointers, DVLD pipeline and output mux.

Test Plan:
- NB=16, AW=5, RD_LAT=2: write 32 words with DR=i, DI=-i and WLAST on i=31 -> BANK_FULL=01, RRDY=1. Read ADDRR=0..31 -> DOR=i, DOI=-i two cycles later with DVLD continuous.
- Stream three frames back-to-back, with frame 2 written while frame 1 is read -> no OVF/UNF and outputs in frame order. With FFT_BITREV_RD_EN defined, ADDRR=1 returns word 16.
- Fill both banks with no reads -> WRDY=0. An extra WE sets OVF=1 and bank contents are unchanged.
- RE with both banks EMPTY -> UNF=1, DVLD stays 0.
- Toggle ED=0 for 3 cycles mid-read -> DVLD and DOR hold, and the read pipeline resumes without word loss.
- Assert RSTN low mid-frame with DVLD in flight -> all outputs 0 immediately; after release, WRDY=1 and RRDY=0.
